// File: rtl/vec_chk_pkg.sv
// vec_chk_pkg: symbol encodings, FSM states and counter limits shared by the vec_chk files
package vec_chk_pkg;
    localparam logic [1:0] SYM_0 = 2'b00;
    localparam logic [1:0] SYM_1 = 2'b01;
    localparam logic [1:0] SYM_X = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_SKIP, ST_CHECK, ST_DONE} state_t;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return v == CNT_MAX ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/vec_chk_fifo.sv
// vec_chk_fifo: synchronous FIFO for expected entries; full/empty decoded from the occupancy register
module vec_chk_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/vec_chk.sv
// vec_chk: expected-vector response checker with don't-care masking and saturating mismatch count.
// Define VEC_CHK_FAILCAP_EN to build the first-failure capture (fail_idx/fail_obs); otherwise they read 0.
module vec_chk
    import vec_chk_pkg::*;
#(
    parameter int W = 4,
    parameter int DEPTH = 8,
    parameter int SKIP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             exp_vld,
    output logic             exp_rdy,
    input  logic [2*W-1:0]   exp_sym,
    input  logic             exp_last,
    input  logic             smp,
    input  logic [W-1:0]     obs,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic             underflow,
    output logic [CNT_W-1:0] fail_idx,
    output logic [W-1:0]     fail_obs
);
    state_t state;
    logic [2*W:0] head;
    logic [W-1:0] care, val;
    logic [7:0] skip_cnt;
    logic full, empty, smp_chk, pop, mism, err_ev, begin_run;

    vec_chk_fifo #(.WIDTH(2*W+1), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(exp_vld),
        .din({exp_last, exp_sym}),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty)
    );

    for (genvar i = 0; i < W; i++) begin : g_sym
        assign care[i] = (head[2*i+:2] & SYM_X) == SYM_0;
        assign val[i] = head[2*i+:2] == SYM_1;
    end

    assign mism = |(care & (val ^ obs));
    assign smp_chk = smp && state == ST_CHECK;
    assign pop = smp_chk & ~empty;
    // an empty FIFO at a checking strobe counts as an error just like a mismatch
    assign err_ev = smp_chk & (empty | mism);
    assign begin_run = start && (state == ST_IDLE || state == ST_DONE);
    assign exp_rdy = ~full;
    assign busy = state == ST_SKIP || state == ST_CHECK;
    assign done = state == ST_DONE;
    assign pass = done && err_cnt == '0 && !underflow;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= ST_IDLE;
            skip_cnt <= '0;
            err_cnt <= '0;
            underflow <= 1'b0;
        end else if (begin_run) begin
            state <= SKIP == 0 ? ST_CHECK : ST_SKIP;
            skip_cnt <= 8'(SKIP);
            err_cnt <= '0;
            underflow <= 1'b0;
        end else begin
            if (smp && state == ST_SKIP) begin
                skip_cnt <= skip_cnt - 8'd1;
                if (skip_cnt == 8'd1) state <= ST_CHECK;
            end
            if (err_ev) err_cnt <= sat_inc(err_cnt);
            if (smp_chk & empty) underflow <= 1'b1;
            if (pop && head[2*W]) state <= ST_DONE;
        end

`ifdef VEC_CHK_FAILCAP_EN
    logic [CNT_W-1:0] idx;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            idx <= '0;
            fail_idx <= '0;
            fail_obs <= '0;
        end else if (begin_run) begin
            idx <= '0;
            fail_idx <= '0;
            fail_obs <= '0;
        end else begin
            if (pop) idx <= sat_inc(idx);
            if (err_ev && err_cnt == '0) begin
                fail_idx <= idx;
                fail_obs <= obs;
            end
        end
`else
    assign fail_idx = '0;
    assign fail_obs = '0;
`endif
endmodule

// File: tb/tb_vec_chk.sv
// tb_vec_chk: table vectors, directed corner sequences and random traffic on two vec_chk instances (SKIP=0 and SKIP=2)
module tb_vec_chk;
`ifdef VEC_CHK_FAILCAP_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif
    localparam int SKP [2] = '{0, 2};

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, exp_vld = 1'b0, exp_last = 1'b0, smp = 1'b0;
    logic [5:0] exp_sym = '0;
    logic [2:0] obs = '0;
    logic [1:0] rdy, busy, done, pass, und;
    logic [7:0] ec [2];
    logic [7:0] fi [2];
    logic [2:0] fo [2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vec_chk #(.W(3), .DEPTH(8), .SKIP(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .exp_vld(exp_vld), .exp_rdy(rdy[0]),
        .exp_sym(exp_sym), .exp_last(exp_last), .smp(smp), .obs(obs), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_cnt(ec[0]), .underflow(und[0]),
        .fail_idx(fi[0]), .fail_obs(fo[0])
    );
    vec_chk #(.W(3), .DEPTH(8), .SKIP(2)) u1 (
        .clk(clk), .rst(rst), .start(start), .exp_vld(exp_vld), .exp_rdy(rdy[1]),
        .exp_sym(exp_sym), .exp_last(exp_last), .smp(smp), .obs(obs), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_cnt(ec[1]), .underflow(und[1]),
        .fail_idx(fi[1]), .fail_obs(fo[1])
    );

    // reference model: run phase 0=idle 1=skip 2=check 3=done, plus a queue of {last, symbols}
    int ms [2], msk [2], merr [2], midx [2], mfi [2], mfo [2];
    bit mund [2];
    logic [6:0] q0 [$];
    logic [6:0] q1 [$];

    function automatic bit mismatch(input logic [5:0] s, input logic [2:0] o);
        bit bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (s[2*i+1] == 1'b0 && s[2*i] != o[i]) bad = 1;
        end
        return bad;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ms[k] = 0; msk[k] = 0; merr[k] = 0; midx[k] = 0; mfi[k] = 0; mfo[k] = 0; mund[k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [6:0] q [$];
            logic [6:0] e;
            int n;
            if (k == 0) q = q0; else q = q1;
            n = q.size();
            if (ms[k] == 0 || ms[k] == 3) begin
                if (start) begin
                    ms[k] = SKP[k] == 0 ? 2 : 1;
                    msk[k] = SKP[k]; merr[k] = 0; mund[k] = 0; midx[k] = 0; mfi[k] = 0; mfo[k] = 0;
                end
            end else if (ms[k] == 1) begin
                if (smp) begin
                    msk[k]--;
                    if (msk[k] == 0) ms[k] = 2;
                end
            end else if (smp) begin
                if (n == 0) begin
                    if (merr[k] == 0) begin mfi[k] = midx[k]; mfo[k] = obs; end
                    mund[k] = 1;
                    merr[k] = merr[k] < 255 ? merr[k] + 1 : 255;
                end else begin
                    e = q.pop_front();
                    if (mismatch(e[5:0], obs)) begin
                        if (merr[k] == 0) begin mfi[k] = midx[k]; mfo[k] = obs; end
                        merr[k] = merr[k] < 255 ? merr[k] + 1 : 255;
                    end
                    midx[k] = midx[k] < 255 ? midx[k] + 1 : 255;
                    if (e[6]) ms[k] = 3;
                end
            end
            if (exp_vld && n < 8) q.push_back({exp_last, exp_sym});
            if (k == 0) q0 = q; else q1 = q;
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d: got %0h want %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int n = k == 0 ? q0.size() : q1.size();
            chk("exp_rdy", k, 32'(rdy[k]), 32'(n < 8));
            chk("busy", k, 32'(busy[k]), 32'(ms[k] == 1 || ms[k] == 2));
            chk("done", k, 32'(done[k]), 32'(ms[k] == 3));
            chk("pass", k, 32'(pass[k]), 32'(ms[k] == 3 && merr[k] == 0 && !mund[k]));
            chk("err_cnt", k, 32'(ec[k]), merr[k]);
            chk("underflow", k, 32'(und[k]), 32'(mund[k]));
            chk("fail_idx", k, 32'(fi[k]), FC ? mfi[k] : 0);
            chk("fail_obs", k, 32'(fo[k]), FC ? mfo[k] : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [5:0] s, input logic l);
        exp_vld = 1'b1; exp_sym = s; exp_last = l;
        tick();
        exp_vld = 1'b0; exp_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic strobe(input logic [2:0] o);
        smp = 1'b1; obs = o;
        tick();
        smp = 1'b0;
    endtask

    typedef struct {
        logic [5:0] sym;
        logic [2:0] obs;
        int err;
        bit pass;
    } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{6'b00_01_00, 3'b010, 0, 1'b1};
        tbl[1] = '{6'b00_01_00, 3'b011, 1, 1'b0};
        tbl[2] = '{6'b10_10_10, 3'b101, 0, 1'b1};
        tbl[3] = '{6'b01_01_01, 3'b111, 0, 1'b1};
        tbl[4] = '{6'b01_01_01, 3'b110, 1, 1'b0};
        tbl[5] = '{6'b11_00_11, 3'b111, 1, 1'b0};
        tbl[6] = '{6'b11_00_11, 3'b101, 0, 1'b1};
        tbl[7] = '{6'b00_00_00, 3'b000, 0, 1'b1};
        model_reset();
        @(negedge clk);
        check_all();
        chk("reset_rdy", 0, 32'(rdy[0]), 1);
        chk("reset_busy", 0, 32'(busy[0]), 0);
        @(negedge clk);
        rst = 1'b0;

        // one-entry runs exercising the comparator and mask
        for (int v = 0; v < 8; v++) begin
            push(tbl[v].sym, 1'b1);
            pulse_start();
            strobe(tbl[v].obs);
            chk("tbl_err", v, 32'(ec[0]), tbl[v].err);
            chk("tbl_pass", v, 32'(pass[0]), 32'(tbl[v].pass));
        end

        // two-entry passing run
        do_reset();
        push(6'b00_01_00, 1'b0);
        push(6'b00_01_10, 1'b1);
        pulse_start();
        strobe(3'b010);
        strobe(3'b011);
        chk("a_done", 0, 32'(done[0]), 1);
        chk("a_pass", 0, 32'(pass[0]), 1);
        chk("a_err", 0, 32'(ec[0]), 0);

        // second strobe mismatches
        push(6'b00_01_00, 1'b0);
        push(6'b00_01_10, 1'b1);
        pulse_start();
        strobe(3'b010);
        strobe(3'b000);
        chk("b_err", 0, 32'(ec[0]), 1);
        chk("b_fidx", 0, 32'(fi[0]), FC ? 1 : 0);
        chk("b_fobs", 0, 32'(fo[0]), 0);
        chk("b_pass", 0, 32'(pass[0]), 0);
        chk("b_done", 0, 32'(done[0]), 1);

        // settle window on the SKIP=2 instance
        do_reset();
        push(6'b01_10_10, 1'b1);
        pulse_start();
        strobe(3'b000);
        chk("c_busy", 1, 32'(busy[1]), 1);
        strobe(3'b000);
        chk("c_notdone", 1, 32'(done[1]), 0);
        strobe(3'b100);
        chk("c_done", 1, 32'(done[1]), 1);
        chk("c_pass", 1, 32'(pass[1]), 1);

        // underflow keeps the run open
        do_reset();
        push(6'b00_01_00, 1'b0);
        pulse_start();
        strobe(3'b010);
        strobe(3'b010);
        strobe(3'b010);
        chk("d_err", 0, 32'(ec[0]), 2);
        chk("d_under", 0, 32'(und[0]), 1);
        chk("d_busy", 0, 32'(busy[0]), 1);

        // fill to full, hold the ninth, pop while full rejects the push
        do_reset();
        exp_vld = 1'b1; exp_sym = 6'b10_10_10; exp_last = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("e_full", 0, 32'(rdy[0]), 0);
        tick();
        tick();
        chk("e_held", 0, 32'(rdy[0]), 0);
        pulse_start();
        smp = 1'b1;
        tick();
        smp = 1'b0;
        chk("e_popfull", 0, 32'(rdy[0]), 1);
        tick();
        chk("e_refill", 0, 32'(rdy[0]), 0);
        exp_vld = 1'b0;

        // asynchronous reset mid-run, then a clean run
        do_reset();
        push(6'b00_01_00, 1'b0);
        push(6'b00_01_00, 1'b0);
        pulse_start();
        strobe(3'b000);
        chk("f_err", 0, 32'(ec[0]), 1);
        do_reset();
        chk("f_rst_err", 0, 32'(ec[0]), 0);
        chk("f_rst_rdy", 0, 32'(rdy[0]), 1);
        chk("f_rst_busy", 0, 32'(busy[0]), 0);
        push(6'b00_01_00, 1'b1);
        pulse_start();
        strobe(3'b010);
        chk("f_pass", 0, 32'(pass[0]), 1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            exp_vld = $urandom_range(0, 2) != 0;
            exp_sym = 6'($urandom);
            exp_last = $urandom_range(0, 5) == 0;
            start = $urandom_range(0, 15) == 0;
            smp = $urandom_range(0, 1) == 1;
            obs = 3'($urandom);
            tick();
        end
        exp_vld = 1'b0; start = 1'b0; smp = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
